mem_pack: RTL

MEM_PACK -- requirements
Module: mem_pack

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_pack_if.sv | 35 +++
 rtl/mem_pack_ram.sv | 62 ++++++
 rtl/mem_pack.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the lane-packing memory: the pack-buffer state
// type and a helper that sizes the lane-index field of an element address.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    // Pack buffer is EMPTY when no lane is held, FILL while any lane waits
    // to be committed.
    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } pack_state_e;

    // Number of low element-address bits that select a lane within a word.
    function automatic int lane_w(input int packs);
        return (packs > 1) ? $clog2(packs) : 1;
    endfunction

endpackage

// File: rtl/mem_pack_if.sv
// ---------------------------------------------------------------------------
// mem_pack_if
// Element-level write/read bus of the lane-packing memory.
//   master : drives wr_valid/wr_addr/wr_data/flush/rd_en/rd_addr,
//            observes wr_ready/pend/rd_valid/rd_data.
//   slave  : the memory side of the same signals.
// ---------------------------------------------------------------------------
interface mem_pack_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             flush;
    logic             pend;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, flush, rd_en, rd_addr,
        input  wr_ready, pend, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, flush, rd_en, rd_addr,
        output wr_ready, pend, rd_valid, rd_data
    );

endinterface

// File: rtl/mem_pack_ram.sv
// ---------------------------------------------------------------------------
// mem_pack_ram
// Word-wide storage with a lane-masked write port and a registered read port.
//   clkA      : clock
//   rst       : synchronous active-high reset (read register only)
//   we_mask_i : per-lane write enable for word waddr_i
//   waddr_i   : word address of the write
//   wdata_i   : full word of write data, lane i at [(i+1)*WIDTH-1 -: WIDTH]
//   rd_en_i   : read request; rdata_o updates one cycle later
//   raddr_i   : word address of the read
//   rdata_o   : registered read word, held while rd_en_i is low
// A read and a write to the same word in one cycle return the old contents.
// ---------------------------------------------------------------------------
module mem_pack_ram #(
    parameter int WIDTH = 32,
    parameter int PACKS = 4,
    parameter int WORDS = 128,
    parameter int WA    = 7
) (
    input  logic                   clkA,
    input  logic                   rst,
    input  logic [PACKS-1:0]       we_mask_i,
    input  logic [WA-1:0]          waddr_i,
    input  logic [WIDTH*PACKS-1:0] wdata_i,
    input  logic                   rd_en_i,
    input  logic [WA-1:0]          raddr_i,
    output logic [WIDTH*PACKS-1:0] rdata_o
);

    logic [WIDTH*PACKS-1:0] mem [WORDS];
    logic [WIDTH*PACKS-1:0] rdata_q;

`ifndef SYNTHESIS
    // Simulation starts from a known all-zero array.
    initial begin
        for (int w = 0; w < WORDS; w++) begin
            mem[w] = '0;
        end
    end
`endif

    // NOTE: the array has no reset; clearing it would turn the RAM into
    // flops. Only the read register below is reset.
    always @(posedge clkA) begin
        for (int i = 0; i < PACKS; i++) begin
            if (we_mask_i[i]) begin
                mem[waddr_i][i*WIDTH +: WIDTH] <= wdata_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clkA) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_pack.sv
// ---------------------------------------------------------------------------
// mem_pack
// Element-addressed memory that gathers WIDTH-bit element writes into a
// PACKS-lane buffer and commits them to a word-wide RAM with a lane mask.
//   clkA : clock
//   rst  : synchronous active-high reset
//   bus  : mem_pack_if.slave
//          wr_valid/wr_ready/wr_addr/wr_data - element write handshake
//          flush - commit the pending buffer, pend - buffer holds lanes
//          rd_en/rd_addr - element read, rd_valid/rd_data after RD_LAT
// Build option: define MEM_PACK_BYPASS_EN to forward uncommitted buffer
// lanes to reads of the same word; otherwise reads see the RAM only.
// ---------------------------------------------------------------------------
module mem_pack
    import mem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int PACKS  = 4,
    parameter int RD_LAT = 1
) (
    input  logic        clkA,
    input  logic        rst,
    mem_pack_if.slave   bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = lane_w(PACKS);
    localparam int WW    = AW - LW;
    localparam int WORDS = DEPTH / PACKS;

    // ------------------------------------------------------------------
    // Write side: pack buffer
    // ------------------------------------------------------------------
    pack_state_e                  state_q, state_d;
    logic [PACKS-1:0]             mask_q, mask_d;
    logic [WW-1:0]                waddr_q, waddr_d;
    logic [PACKS-1:0][WIDTH-1:0]  lanes_q, lanes_d;
    logic                         rdy_q;

    logic                         accept;
    logic                         commit;
    logic                         pend;
    logic [PACKS-1:0]             we_mask;
    logic [WW-1:0]                in_word;
    logic [LW-1:0]                in_lane;

    assign in_word = bus.wr_addr[AW-1:LW];
    assign in_lane = bus.wr_addr[LW-1:0];
    assign accept  = bus.wr_valid & rdy_q;

    // The buffer is flushed to RAM when it is full (one cycle after the
    // last lane arrived), on request, or when a new element belongs to a
    // different word. An element accepted in the same cycle is loaded
    // into the freshly emptied buffer.
    assign commit = (state_q == FILL) &&
                    ((&mask_q) || bus.flush || (accept && (in_word != waddr_q)));

    // Ready comes up on the first clock edge that samples rst low, so it
    // stays low for the cycle following reset release.
    always_ff @(posedge clkA) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, whatever the order.
    always_ff @(posedge clkA) begin
        if (rst) begin
            state_q <= EMPTY;
            mask_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            waddr_q <= waddr_d;
        end
    end

    // Lane data is qualified by mask_q, so it needs no reset; clearing the
    // mask is what discards an interrupted fill.
    always_ff @(posedge clkA) begin
        lanes_q <= lanes_d;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        waddr_d = waddr_q;
        lanes_d = lanes_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d          = FILL;
                    waddr_d          = in_word;
                    mask_d           = '0;
                    mask_d[in_lane]  = 1'b1;
                    lanes_d[in_lane] = bus.wr_data;
                end
            end
            FILL: begin
                if (commit) begin
                    if (accept) begin
                        waddr_d          = in_word;
                        mask_d           = '0;
                        mask_d[in_lane]  = 1'b1;
                        lanes_d[in_lane] = bus.wr_data;
                    end else begin
                        state_d = EMPTY;
                        mask_d  = '0;
                    end
                end else if (accept) begin
                    mask_d[in_lane]  = 1'b1;
                    lanes_d[in_lane] = bus.wr_data;
                end
            end
            default: begin
                state_d = EMPTY;
                mask_d  = '0;
            end
        endcase
    end

    always_comb begin
        pend    = (state_q == FILL);
        we_mask = commit ? mask_q : '0;
    end

    assign bus.wr_ready = rdy_q;
    assign bus.pend     = pend;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WW-1:0]               rd_word;
    logic [LW-1:0]               rd_lane;
    logic [PACKS-1:0][WIDTH-1:0] ram_rdata;

    assign rd_word = bus.rd_addr[AW-1:LW];
    assign rd_lane = bus.rd_addr[LW-1:0];

    mem_pack_ram #(
        .WIDTH (WIDTH),
        .PACKS (PACKS),
        .WORDS (WORDS),
        .WA    (WW)
    ) u_ram (
        .clkA      (clkA),
        .rst       (rst),
        .we_mask_i (we_mask),
        .waddr_i   (waddr_q),
        .wdata_i   (lanes_q),
        .rd_en_i   (bus.rd_en),
        .raddr_i   (rd_word),
        .rdata_o   (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read side: first stage sits alongside the RAM read register
    // ------------------------------------------------------------------
    logic [LW-1:0]    rd_lane_q;
    logic             v1_q;
    logic [WIDTH-1:0] stage1;

    // Lane select is captured only with a request, so the muxed data
    // stays put while no read is in flight.
    always_ff @(posedge clkA) begin
        if (rst) begin
            rd_lane_q <= '0;
            v1_q      <= 1'b0;
        end else begin
            v1_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_lane_q <= rd_lane;
            end
        end
    end

`ifdef MEM_PACK_BYPASS_EN
    logic             byp_hit_q;
    logic [WIDTH-1:0] byp_data_q;

    // A set mask bit implies the buffer is in FILL, so mask plus word
    // match is enough to decide the forward.
    always_ff @(posedge clkA) begin
        if (rst) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else if (bus.rd_en) begin
            byp_hit_q  <= mask_q[rd_lane] && (waddr_q == rd_word);
            byp_data_q <= lanes_q[rd_lane];
        end
    end

    assign stage1 = byp_hit_q ? byp_data_q : ram_rdata[rd_lane_q];
`else
    assign stage1 = ram_rdata[rd_lane_q];
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             v2_q;
            logic [WIDTH-1:0] d2_q;

            always_ff @(posedge clkA) begin
                if (rst) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        d2_q <= stage1;
                    end
                end
            end

            assign bus.rd_valid = v2_q;
            assign bus.rd_data  = d2_q;
        end else begin : g_lat1
            assign bus.rd_valid = v1_q;
            assign bus.rd_data  = stage1;
        end
    endgenerate

endmodule
